// File: rtl/futurefpga_cfg_pkg.sv
// Shared definitions for the slice-array configuration loader.
// Holds the CFG word width, stream magic byte, bytes per slice and FSM state type.
// No ports; imported by the interface, the frame assembler and the loader top.
package futurefpga_cfg_pkg;

  localparam int         CFG_W           = 20;
  localparam logic [7:0] CFG_MAGIC       = 8'hA5;
  localparam int         BYTES_PER_SLICE = 3;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHECK,
    RELEASE,
    DONE,
    ERR
  } cfg_state_t;

endpackage

// File: rtl/futurefpga_cfg_loader_if.sv
// Bitstream handshake plus configuration/status outputs of the loader.
// master: bitstream source (drives START, IN_DATA, IN_VALID; observes the rest).
// slave: the loader (accepts bytes, drives IN_READY, CFG_BUS and status flags).
interface futurefpga_cfg_loader_if
  import futurefpga_cfg_pkg::*;
#(
  parameter int NUM_SLICES = 16
);
  logic                        START;
  logic [7:0]                  IN_DATA;
  logic                        IN_VALID;
  logic                        IN_READY;
  logic [CFG_W*NUM_SLICES-1:0] CFG_BUS;
  logic                        FABRIC_RST;
  logic                        CFG_DONE;
  logic                        CFG_ERR;

  modport master (
    output START, IN_DATA, IN_VALID,
    input  IN_READY, CFG_BUS, FABRIC_RST, CFG_DONE, CFG_ERR
  );

  modport slave (
    input  START, IN_DATA, IN_VALID,
    output IN_READY, CFG_BUS, FABRIC_RST, CFG_DONE, CFG_ERR
  );
endinterface

// File: rtl/futurefpga_cfg_frame_asm.sv
// Assembles three accepted payload bytes into one 20-bit CFG word.
// Ports: clk_i/rst_i, clr_i (restart framing), byte_vld_i/byte_dat_i (accepted byte),
//        word_valid_o/word_o (complete word, same cycle as byte2), pad_err_o (byte2 upper nibble set).
module futurefpga_cfg_frame_asm
  import futurefpga_cfg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_dat_i,
  output logic             word_valid_o,
  output logic [CFG_W-1:0] word_o,
  output logic             pad_err_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] low_q, low_d;
  logic        last_byte;

  assign last_byte = (byte_cnt_q == 2'(BYTES_PER_SLICE - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    low_d      = low_q;
    if (clr_i) begin
      byte_cnt_d = 2'd0;
      low_d      = 16'h0;
    end else if (byte_vld_i) begin
      byte_cnt_d = last_byte ? 2'd0 : byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd0) low_d[7:0]  = byte_dat_i;
      if (byte_cnt_q == 2'd1) low_d[15:8] = byte_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q <= 2'd0;
      low_q      <= 16'h0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      low_q      <= low_d;
    end
  end

  // The third byte completes the word combinationally so the loader can
  // store it on the same edge that accepts it.
  assign pad_err_o    = byte_vld_i & last_byte & (byte_dat_i[7:4] != 4'h0);
  assign word_valid_o = byte_vld_i & last_byte & ~pad_err_o;
  assign word_o       = {byte_dat_i[3:0], low_q};

endmodule

// File: rtl/futurefpga_cfg_loader.sv
// Loads and checks a byte-wide bitstream, commits all slice CFG words atomically,
// and holds the fabric in reset from load start until the new config is stable.
// Ports: CLK/RST, bus (slave): START, IN_DATA/IN_VALID/IN_READY, CFG_BUS, FABRIC_RST, CFG_DONE, CFG_ERR.
module futurefpga_cfg_loader
  import futurefpga_cfg_pkg::*;
#(
  parameter int NUM_SLICES = 16
)
(
  input logic                    CLK,
  input logic                    RST,
  futurefpga_cfg_loader_if.slave bus
);

  localparam int             SW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int             BUS_W      = CFG_W * NUM_SLICES;
  localparam logic [SW-1:0]  LAST_SLICE = SW'(NUM_SLICES - 1);

  cfg_state_t       state_q, state_d;
  logic [SW-1:0]    slice_q, slice_d;
  logic [7:0]       xor_q, xor_d;
  logic [BUS_W-1:0] shadow_q, shadow_d;
  logic [BUS_W-1:0] cfg_bus_q, cfg_bus_d;
  logic             fabric_rst_q, fabric_rst_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             in_ready;
  logic             xfer;
  logic             enter_hdr;
  logic             asm_vld;
  logic             word_valid;
  logic             pad_err;
  logic [CFG_W-1:0] word;

  assign in_ready  = (state_q == HDR) || (state_q == LOAD) || (state_q == CHECK);
  assign xfer      = bus.IN_VALID & in_ready;
  assign enter_hdr = (state_d == HDR) && (state_q != HDR);
  assign asm_vld   = xfer && (state_q == LOAD);

  futurefpga_cfg_frame_asm u_frame_asm (
    .clk_i        (CLK),
    .rst_i        (RST),
    .clr_i        (enter_hdr),
    .byte_vld_i   (asm_vld),
    .byte_dat_i   (bus.IN_DATA),
    .word_valid_o (word_valid),
    .word_o       (word),
    .pad_err_o    (pad_err)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = HDR;
      HDR:     if (xfer) state_d = (bus.IN_DATA == CFG_MAGIC) ? LOAD : ERR;
      LOAD: begin
        if (pad_err)                                 state_d = ERR;
        else if (word_valid && slice_q == LAST_SLICE) state_d = CHECK;
      end
      CHECK:   if (xfer) state_d = (bus.IN_DATA == xor_q) ? RELEASE : ERR;
      RELEASE: state_d = DONE;
      DONE:    if (bus.START) state_d = HDR;
      ERR:     if (bus.START) state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: status flags are registered from the next state so they
  // change on the same edge as the state they describe.
  always_comb begin
    fabric_rst_d = (state_d != DONE);
    cfg_done_d   = (state_d == DONE);
    cfg_err_d    = (state_d == ERR);
  end

  // Datapath: slice counter, running XOR, shadow and commit.
  always_comb begin
    slice_d   = slice_q;
    xor_d     = xor_q;
    shadow_d  = shadow_q;
    cfg_bus_d = cfg_bus_q;
    if (enter_hdr) begin
      slice_d = '0;
      xor_d   = 8'h0;
    end else if (asm_vld) begin
      xor_d = xor_q ^ bus.IN_DATA;
      if (word_valid) begin
        shadow_d[slice_q*CFG_W +: CFG_W] = word;
        slice_d = slice_q + 1'b1;
      end
    end else if (xfer && state_q == CHECK && bus.IN_DATA == xor_q) begin
      // Commit on the checksum edge; release follows one cycle later.
      cfg_bus_d = shadow_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slice_q      <= '0;
      xor_q        <= 8'h0;
      shadow_q     <= '0;
      cfg_bus_q    <= '0;
      fabric_rst_q <= 1'b1;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      slice_q      <= slice_d;
      xor_q        <= xor_d;
      shadow_q     <= shadow_d;
      cfg_bus_q    <= cfg_bus_d;
      fabric_rst_q <= fabric_rst_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.IN_READY   = in_ready;
  assign bus.CFG_BUS    = cfg_bus_q;
  assign bus.FABRIC_RST = fabric_rst_q;
  assign bus.CFG_DONE   = cfg_done_q;
  assign bus.CFG_ERR    = cfg_err_q;

endmodule

// File: tb/tb_futurefpga_cfg_loader.sv
// Bench for the configuration loader with two slices.
// Streams directed and random bitstreams with random valid gaps and compares
// accepted byte count, committed CFG_BUS and status against a stream-level model.
module tb_futurefpga_cfg_loader;
  import futurefpga_cfg_pkg::*;

  localparam int NS = 2;
  localparam int NB = 3 * NS + 2;
  localparam int BW = CFG_W * NS;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  futurefpga_cfg_loader_if #(.NUM_SLICES(NS)) bus_if ();

  futurefpga_cfg_loader #(.NUM_SLICES(NS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_cfg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream-level reference: decides how many bytes the loader takes,
  // whether the load succeeds and what configuration it yields.
  function automatic void model(input logic [7:0] s[$], output int n_acc,
                                output bit ok, output logic [BW-1:0] cfg);
    logic [7:0] x;
    logic [7:0] v;
    logic [7:0] b0, b1;
    x = 8'h0; ok = 1'b0; cfg = '0; n_acc = 1;
    if (s[0] != CFG_MAGIC) return;
    for (int sl = 0; sl < NS; sl++) begin
      b0 = s[1 + 3*sl];
      b1 = s[2 + 3*sl];
      v  = s[3 + 3*sl];
      n_acc += 3;
      x = x ^ b0 ^ b1 ^ v;
      if (v[7:4] != 4'h0) return;
      cfg[CFG_W*sl +: CFG_W] = {v[3:0], b1, b0};
    end
    n_acc++;
    ok = (s[NB-1] == x);
  endfunction

  function automatic void make_stream(input logic [BW-1:0] cfg, output logic [7:0] s[$]);
    logic [CFG_W-1:0] w;
    logic [7:0] x;
    s = {};
    x = 8'h0;
    s.push_back(CFG_MAGIC);
    for (int sl = 0; sl < NS; sl++) begin
      w = cfg[CFG_W*sl +: CFG_W];
      s.push_back(w[7:0]);
      s.push_back(w[15:8]);
      s.push_back({4'h0, w[19:16]});
      x = x ^ w[7:0] ^ w[15:8] ^ {4'h0, w[19:16]};
    end
    s.push_back(x);
  endfunction

  // Pulse START, then offer up to 'limit' bytes with random gaps. Returns at the
  // falling edge right after the last accepted byte (or once IN_READY is low).
  task automatic run_load(input logic [7:0] s[$], input int max_gap, input int limit,
                          output int n_acc);
    int g;
    n_acc = 0;
    @(negedge CLK);
    bus_if.START = 1'b1;
    @(negedge CLK);
    bus_if.START = 1'b0;
    chk("hdr_ready", bus_if.IN_READY, 1);
    chk("hdr_fabric_rst", bus_if.FABRIC_RST, 1);
    chk("hdr_done", bus_if.CFG_DONE, 0);
    chk("hdr_err", bus_if.CFG_ERR, 0);
    for (int i = 0; i < limit; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) @(negedge CLK);
      if (!bus_if.IN_READY) break;
      bus_if.IN_VALID = 1'b1;
      bus_if.IN_DATA  = s[i];
      @(negedge CLK);
      n_acc++;
      bus_if.IN_VALID = 1'b0;
      bus_if.IN_DATA  = 8'h00;
    end
  endtask

  task automatic do_load(input logic [7:0] s[$], input int max_gap);
    int n_acc, m_acc;
    bit m_ok;
    logic [BW-1:0] m_cfg;
    model(s, m_acc, m_ok, m_cfg);
    run_load(s, max_gap, NB, n_acc);
    chk("accepted_bytes", n_acc, m_acc);
    if (m_ok) begin
      chk("commit_bus", bus_if.CFG_BUS, m_cfg);
      chk("commit_fabric_rst", bus_if.FABRIC_RST, 1);
      chk("commit_done", bus_if.CFG_DONE, 0);
      chk("commit_ready", bus_if.IN_READY, 0);
      @(negedge CLK);
      chk("release_fabric_rst", bus_if.FABRIC_RST, 0);
      chk("release_done", bus_if.CFG_DONE, 1);
      chk("release_err", bus_if.CFG_ERR, 0);
      chk("release_bus", bus_if.CFG_BUS, m_cfg);
      exp_cfg = m_cfg;
    end else begin
      chk("err_flag", bus_if.CFG_ERR, 1);
      chk("err_ready", bus_if.IN_READY, 0);
      chk("err_fabric_rst", bus_if.FABRIC_RST, 1);
      chk("err_done", bus_if.CFG_DONE, 0);
      chk("err_bus_kept", bus_if.CFG_BUS, exp_cfg);
    end
  endtask

  initial begin
    logic [7:0] s[$];
    logic [BW-1:0] rc;
    int f, sl, n_acc;

    RST = 1'b1;
    bus_if.START    = 1'b0;
    bus_if.IN_VALID = 1'b0;
    bus_if.IN_DATA  = 8'h00;
    exp_cfg = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", bus_if.IN_READY, 0);
    chk("rst_fabric_rst", bus_if.FABRIC_RST, 1);
    chk("rst_done", bus_if.CFG_DONE, 0);
    chk("rst_err", bus_if.CFG_ERR, 0);
    chk("rst_bus", bus_if.CFG_BUS, 0);

    // Clean directed load.
    s = '{8'hA5, 8'h00, 8'h80, 8'h03, 8'h96, 8'h69, 8'h01, 8'h7D};
    do_load(s, 0);
    chk("clean_bus_const", bus_if.CFG_BUS, {20'h16996, 20'h38000});

    // Bad magic.
    s = '{8'h5A, 8'h00, 8'h80, 8'h03, 8'h96, 8'h69, 8'h01, 8'h7D};
    do_load(s, 0);

    // Bad checksum.
    s = '{8'hA5, 8'h00, 8'h80, 8'h03, 8'h96, 8'h69, 8'h01, 8'h7C};
    do_load(s, 0);
    chk("badsum_bus_const", bus_if.CFG_BUS, {20'h16996, 20'h38000});

    // Pad violation on the first slice's third byte.
    s = '{8'hA5, 8'h00, 8'h80, 8'h13, 8'h96, 8'h69, 8'h01, 8'h7D};
    do_load(s, 0);

    // Clean stream under random valid gaps.
    s = '{8'hA5, 8'h00, 8'h80, 8'h03, 8'h96, 8'h69, 8'h01, 8'h7D};
    for (int k = 0; k < 4; k++) do_load(s, 5);

    // Random configurations with an occasional injected fault.
    for (int k = 0; k < 30; k++) begin
      rc = BW'({$urandom(), $urandom()});
      make_stream(rc, s);
      f = $urandom_range(3, 0);
      case (f)
        1: s[0] = s[0] ^ 8'($urandom_range(255, 1));
        2: begin
          sl = $urandom_range(NS - 1, 0);
          s[3 + 3*sl] = s[3 + 3*sl] | {4'($urandom_range(15, 1)), 4'h0};
        end
        3: s[NB-1] = s[NB-1] ^ 8'($urandom_range(255, 1));
        default: ;
      endcase
      do_load(s, $urandom_range(3, 0));
    end

    // Make sure a nonzero config is committed, then reset mid-load.
    make_stream(BW'(40'h12345_ABCDE), s);
    do_load(s, 0);
    run_load(s, 0, 5, n_acc);
    chk("midrst_accepted", n_acc, 5);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_bus", bus_if.CFG_BUS, 0);
    chk("midrst_fabric_rst", bus_if.FABRIC_RST, 1);
    chk("midrst_ready", bus_if.IN_READY, 0);
    chk("midrst_done", bus_if.CFG_DONE, 0);
    chk("midrst_err", bus_if.CFG_ERR, 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_cfg = '0;
    @(negedge CLK);
    chk("postrst_ready", bus_if.IN_READY, 0);
    s = '{8'hA5, 8'h00, 8'h80, 8'h03, 8'h96, 8'h69, 8'h01, 8'h7D};
    do_load(s, 2);
    chk("postrst_bus_const", bus_if.CFG_BUS, {20'h16996, 20'h38000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
